operand_fetch: RTL and testbench
================================

# operand_fetch

Operand-fetch stage sitting directly downstream of instruction decode and upstream of execute. Accepts decoded fields (opcode, iOrReg, rd, rs1, rs2, modifier, imm) and holds the 16 x 32-bit register file. Reads source operands, expands the immediate, and tracks pending writes in a scoreboard so that RAW/WAW hazards stall decode. Drives one registered valid/ready output slot toward execute.

## Interface
Parameters:
- XLEN, 32, datapath and register width
- NREG, 16, register count (4-bit specifiers)

Ports:
- clk  in  1  clock
- clr  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts this cycle; decode gates its ld with this
- opcode  in  5  decoded opcode
- iOrReg  in  1  1 = operand 2 is immediate, 0 = rs2
- rd, rs1, rs2  in  4 each  register specifiers
- modifier  in  2  immediate expansion select
- imm  in  16  raw immediate
- flush  in  1  branch taken; discard slot and input
- wb_en  in  1  writeback strobe
- wb_rd  in  4  writeback register
- wb_data  in  32  writeback value
- out_valid  out  1  output slot holds an instruction
- out_ready  in  1  execute accepts slot
- out_opcode  out  5  registered opcode
- out_rd  out  4  registered destination
- out_wr  out  1  instruction writes rd
- out_op1, out_op2  out  32 each  resolved operands
- out_st  out  32  rs2 register value (store data even when iOrReg=1)

## Operation
- Classes: writes_rd = ~opcode[4]; srcless = (opcode[4:3] == 2'b11), meaning branch/jump reads no registers.
- r0 reads 0; writes to r0 are ignored; r0 is never busy.
- Immediate expansion by modifier:
  - 00: sign-extend
  - 01: zero-extend
  - 10: imm << 16
  - 11: sign-extend
- op2 = iOrReg ? expanded imm : R[rs2].
- Scoreboard `busy[15:0]`:
  - set busy[rd] on issue when writes_rd and rd != 0
  - clear on wb_en for wb_rd
  - same-cycle set and clear of one bit: set wins
- hazard =
  - (!srcless && busy[rs1]), or
  - (!srcless && !iOrReg && busy[rs2]), or
  - (writes_rd && busy[rd]) for WAW.
  - A given rd has at most one writer in flight.
- in_ready = !hazard && !flush && (!out_valid || out_ready).
- Issue = in_valid && in_ready. On issue, the slot loads all out_* fields and sets out_valid.
- Slot drain: if out_valid && out_ready && !issue, clear out_valid.
- Register file: written on wb_en (rd != 0) at the clock edge; reads are combinational.
- flush:
  - clears out_valid
  - if the slot held a valid writes_rd instruction, clears busy[out_rd] (unless same-cycle wb clears it anyway)
  - the input is not accepted.

## Timing
- Reset (clr high at edge) sets:
  - all registers = 0, busy = 0, out_valid = 0
  - all out_* = 0
  - in_ready evaluates to 1 the following cycle
- clr has priority over flush, wb and issue.
- Latency:
  - operands appear on out_* 1 cycle after the issue edge
  - a stalled instruction issues on the first cycle its hazard is clear
- out_* hold stable while out_valid && !out_ready.
- clr mid-stall drops the pending instruction. Decode is responsible for reissuing.

## Configuration
- OPFETCH_WB_BYPASS_EN defined:
  - When wb_en && wb_rd matches a source, operand reads take wb_data.
  - busy[wb_rd] is treated as clear in that cycle's hazard check.
  - Dependent issue happens in the same cycle as writeback.
- Undefined:
  - The hazard uses registered busy only, and reads come from the array.
  - A dependent instruction issues 1 cycle after the writeback edge.

## Test plan
- clr, then read r1..r15 via op1 → all 0; out_valid = 0; in_ready = 1.
- wb r3 = 0x12345678, then issue iOrReg=1, rs1=3, modifier=10, imm=0x00AB → op1 = 0x12345678, op2 = 0x00AB0000, out_valid 1 cycle later.
- Issue writer rd=5, then a reader rs1=5 on the next cycle → in_ready = 0 until wb r5 = 0xCAFE.
  - With OPFETCH_WB_BYPASS_EN: issue in the wb cycle, op1 = 0xCAFE.
  - Without it: issue one cycle later.
- Hold out_ready = 0 with a valid slot, present a new instruction → in_ready = 0 and out_* unchanged; raise out_ready → new instruction loads on the next edge.
- Slot holds writer rd=7; assert flush → out_valid = 0, busy[7] = 0, and a following reader of r7 issues without stall.
- Same cycle: issue writer rd=4 and wb_rd=4 → busy[4] = 1 afterwards. Also write to r0 with 0xFFFFFFFF → op1 with rs1=0 reads 0.

Source files
------------

// File: rtl/operand_fetch_if.sv
// Decode/execute/writeback bundle for the operand-fetch stage.
// The stage uses the slave modport. The surrounding pipeline or bench uses the master modport.
interface operand_fetch_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      opcode;
  logic            iOrReg;
  logic [3:0]      rd;
  logic [3:0]      rs1;
  logic [3:0]      rs2;
  logic [1:0]      modifier;
  logic [15:0]     imm;
  logic            flush;
  logic            wb_en;
  logic [3:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_opcode;
  logic [3:0]      out_rd;
  logic            out_wr;
  logic [XLEN-1:0] out_op1;
  logic [XLEN-1:0] out_op2;
  logic [XLEN-1:0] out_st;

  modport slave (
    input  in_valid, opcode, iOrReg, rd, rs1, rs2, modifier, imm,
    input  flush, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_opcode, out_rd, out_wr,
    output out_op1, out_op2, out_st
  );

  modport master (
    output in_valid, opcode, iOrReg, rd, rs1, rs2, modifier, imm,
    output flush, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_opcode, out_rd, out_wr,
    input  out_op1, out_op2, out_st
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register file, busy scoreboard and one registered slot toward execute.
// Define OPFETCH_WB_BYPASS_EN to forward same-cycle writeback data into reads and hazard checks.
module operand_fetch #(
  parameter int XLEN = 32,
  parameter int NREG = 16
) (
  input  logic                clk,
  input  logic                clr,
  operand_fetch_if.slave      bus
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [NREG-1:0] busy_chk;

  logic            out_valid;
  logic [4:0]      out_opcode;
  logic [3:0]      out_rd;
  logic            out_wr;
  logic [XLEN-1:0] out_op1;
  logic [XLEN-1:0] out_op2;
  logic [XLEN-1:0] out_st;

  logic            writes_rd;
  logic            srcless;
  logic            hazard;
  logic            in_ready;
  logic            issue;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm_ext;
  logic            wb_write;

  assign writes_rd = ~bus.opcode[4];
  assign srcless   = (bus.opcode[4:3] == 2'b11);
  assign wb_write  = bus.wb_en && (bus.wb_rd != 4'd0);

  // NOTE: every always_comb output gets a default on entry so no path leaves it unassigned (no latch).
  always_comb begin
    busy_chk = busy;
`ifdef OPFETCH_WB_BYPASS_EN
    if (bus.wb_en) busy_chk[bus.wb_rd] = 1'b0;
`endif
  end

  always_comb begin
    rs1_val = (bus.rs1 == 4'd0) ? '0 : regs[bus.rs1];
    rs2_val = (bus.rs2 == 4'd0) ? '0 : regs[bus.rs2];
`ifdef OPFETCH_WB_BYPASS_EN
    if (wb_write && bus.wb_rd == bus.rs1) rs1_val = bus.wb_data;
    if (wb_write && bus.wb_rd == bus.rs2) rs2_val = bus.wb_data;
`endif
  end

  always_comb begin
    imm_ext = XLEN'($signed(bus.imm));
    unique case (bus.modifier)
      2'b01:   imm_ext = XLEN'(bus.imm);
      2'b10:   imm_ext = XLEN'({bus.imm, 16'h0000});
      default: imm_ext = XLEN'($signed(bus.imm));
    endcase
  end

  assign hazard = (!srcless && busy_chk[bus.rs1])
               || (!srcless && !bus.iOrReg && busy_chk[bus.rs2])
               || (writes_rd && busy_chk[bus.rd]);

  assign in_ready = !hazard && !bus.flush && (!out_valid || bus.out_ready);
  assign issue    = bus.in_valid && in_ready;

  // The set is applied last so that an issue and a writeback to the same rd in one cycle leave it busy.
  always_comb begin
    busy_nxt = busy;
    if (bus.wb_en) busy_nxt[bus.wb_rd] = 1'b0;
    if (bus.flush && out_valid && out_wr) busy_nxt[out_rd] = 1'b0;
    if (issue && writes_rd && bus.rd != 4'd0) busy_nxt[bus.rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // NOTE: the register array is reset explicitly because clr must return every architectural register to zero.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_write) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      busy       <= '0;
      out_valid  <= 1'b0;
      out_opcode <= '0;
      out_rd     <= '0;
      out_wr     <= 1'b0;
      out_op1    <= '0;
      out_op2    <= '0;
      out_st     <= '0;
    end else begin
      busy <= busy_nxt;
      if (bus.flush) begin
        out_valid <= 1'b0;
      end else if (issue) begin
        out_valid  <= 1'b1;
        out_opcode <= bus.opcode;
        out_rd     <= bus.rd;
        out_wr     <= writes_rd;
        out_op1    <= rs1_val;
        out_op2    <= bus.iOrReg ? imm_ext : rs2_val;
        out_st     <= rs2_val;
      end else if (out_valid && bus.out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_opcode = out_opcode;
  assign bus.out_rd     = out_rd;
  assign bus.out_wr     = out_wr;
  assign bus.out_op1    = out_op1;
  assign bus.out_op2    = out_op2;
  assign bus.out_st     = out_st;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed table, multi-cycle hazard sequences, and a randomized run.
// The randomized run is checked against a queue-based pipeline model.
module tb_operand_fetch;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  operand_fetch_if #(.XLEN(XLEN)) bus ();
  operand_fetch #(.XLEN(XLEN), .NREG(16)) dut (.clk(clk), .clr(clr), .bus(bus));

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [4:0]  opcode;
    logic        ior;
    logic [3:0]  rd, rs1, rs2;
    logic [1:0]  modifier;
    logic [15:0] imm;
    logic [31:0] exp_op1, exp_op2, exp_st;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [4:0]  opcode;
    logic [3:0]  rd;
    logic        wr;
    logic [31:0] op1, op2, st;
  } slot_t;

  vec_t vecs[8];

  logic [31:0] m_regs [16];
  logic [3:0]  m_pend [$];
  slot_t       m_slot;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.opcode = '0; bus.iOrReg = 1'b0; bus.rd = '0;
    bus.rs1 = '0; bus.rs2 = '0; bus.modifier = '0; bus.imm = '0;
    bus.flush = 1'b0; bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic drive(input logic [4:0] opc, input logic ior, input logic [3:0] rd,
                       input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [1:0] modifier, input logic [15:0] imm);
    bus.in_valid = 1'b1; bus.opcode = opc; bus.iOrReg = ior; bus.rd = rd;
    bus.rs1 = rs1; bus.rs2 = rs2; bus.modifier = modifier; bus.imm = imm;
  endtask

  task automatic wb(input logic [3:0] r, input logic [31:0] d);
    bus.wb_en = 1'b1; bus.wb_rd = r; bus.wb_data = d;
    tick();
    bus.wb_en = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_pend.delete();
    m_slot = '{default: '0};
  endtask

  task automatic do_reset();
    idle();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_reset();
  endtask

  // ---------------- reference model ----------------
  function automatic bit pending(input logic [3:0] r);
    if (r == 4'd0) return 1'b0;
`ifdef OPFETCH_WB_BYPASS_EN
    if (bus.wb_en && bus.wb_rd == r) return 1'b0;
`endif
    foreach (m_pend[i]) if (m_pend[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] r);
    if (r == 4'd0) return 32'h0;
`ifdef OPFETCH_WB_BYPASS_EN
    if (bus.wb_en && bus.wb_rd == r) return bus.wb_data;
`endif
    return m_regs[r];
  endfunction

  function automatic logic [31:0] m_imm(input logic [1:0] m, input logic [15:0] v);
    int s;
    s = (v >= 16'h8000) ? int'(v) - 65536 : int'(v);
    if (m == 2'd1) return 32'(v);
    if (m == 2'd2) return 32'(v) * 32'd65536;
    return 32'(s);
  endfunction

  function automatic bit m_ready();
    bit src, wr, haz;
    src = (bus.opcode[4:3] != 2'b11);
    wr  = !bus.opcode[4];
    haz = (src && pending(bus.rs1)) || (src && !bus.iOrReg && pending(bus.rs2))
       || (wr && pending(bus.rd));
    return !haz && !bus.flush && (!m_slot.valid || bus.out_ready);
  endfunction

  task automatic pend_remove(input logic [3:0] r);
    for (int i = m_pend.size() - 1; i >= 0; i--) if (m_pend[i] == r) m_pend.delete(i);
  endtask

  task automatic model_commit(input bit ready);
    slot_t nx;
    bit    iss;
    iss = bus.in_valid && ready;
    if (clr) begin
      model_reset();
      return;
    end
    nx.valid  = 1'b1;
    nx.opcode = bus.opcode;
    nx.rd     = bus.rd;
    nx.wr     = !bus.opcode[4];
    nx.op1    = m_read(bus.rs1);
    nx.st     = m_read(bus.rs2);
    nx.op2    = bus.iOrReg ? m_imm(bus.modifier, bus.imm) : nx.st;
    if (bus.wb_en && bus.wb_rd != 0) m_regs[bus.wb_rd] = bus.wb_data;
    if (bus.wb_en) pend_remove(bus.wb_rd);
    if (bus.flush && m_slot.valid && m_slot.wr) pend_remove(m_slot.rd);
    if (iss && nx.wr && bus.rd != 0) m_pend.push_back(bus.rd);
    if (bus.flush) m_slot.valid = 1'b0;
    else if (iss) m_slot = nx;
    else if (m_slot.valid && bus.out_ready) m_slot.valid = 1'b0;
  endtask

  task automatic rand_cycle();
    bit exp_ready;
    clr           = ($urandom_range(0, 199) == 0);
    bus.in_valid  = ($urandom_range(0, 3) != 0);
    bus.opcode    = 5'($urandom_range(0, 31));
    bus.iOrReg    = 1'($urandom_range(0, 1));
    bus.rd        = 4'($urandom_range(0, 4));
    bus.rs1       = 4'($urandom_range(0, 4));
    bus.rs2       = 4'($urandom_range(0, 4));
    bus.modifier  = 2'($urandom_range(0, 3));
    bus.imm       = 16'($urandom);
    bus.flush     = ($urandom_range(0, 19) == 0);
    bus.out_ready = ($urandom_range(0, 9) < 7);
    bus.wb_data   = $urandom;
    bus.wb_en     = 1'b0;
    if (m_pend.size() > 0 && $urandom_range(0, 2) == 0) begin
      bus.wb_en = 1'b1;
      bus.wb_rd = m_pend[$urandom_range(0, m_pend.size() - 1)];
    end else begin
      bus.wb_en = ($urandom_range(0, 7) == 0);
      bus.wb_rd = 4'($urandom_range(0, 4));
    end
    exp_ready = m_ready();
    #1;
    check("rand in_ready", 32'(bus.in_ready), 32'(exp_ready));
    model_commit(exp_ready);
    tick();
    check("rand out_valid", 32'(bus.out_valid), 32'(m_slot.valid));
    check("rand out_opcode", 32'(bus.out_opcode), 32'(m_slot.opcode));
    check("rand out_rd", 32'(bus.out_rd), 32'(m_slot.rd));
    check("rand out_wr", 32'(bus.out_wr), 32'(m_slot.wr));
    check("rand out_op1", bus.out_op1, m_slot.op1);
    check("rand out_op2", bus.out_op2, m_slot.op2);
    check("rand out_st", bus.out_st, m_slot.st);
  endtask

  // ---------------- test sequence ----------------
  localparam logic [4:0] ALU = 5'b10100;  // reads sources, no rd write
  localparam logic [4:0] WR  = 5'b00010;  // writes rd

  initial begin
    vecs[0] = '{ALU, 1'b1, 4'd1, 4'd3, 4'd2, 2'b10, 16'h00AB, 32'h12345678, 32'h00AB0000, 32'h80000002};
    vecs[1] = '{ALU, 1'b1, 4'd2, 4'd1, 4'd0, 2'b00, 16'h8001, 32'h11111111, 32'hFFFF8001, 32'h00000000};
    vecs[2] = '{ALU, 1'b1, 4'd3, 4'd2, 4'd1, 2'b01, 16'h8001, 32'h80000002, 32'h00008001, 32'h11111111};
    vecs[3] = '{ALU, 1'b1, 4'd4, 4'd0, 4'd3, 2'b11, 16'hFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h12345678};
    vecs[4] = '{ALU, 1'b1, 4'd5, 4'd3, 4'd3, 2'b11, 16'h7FFF, 32'h12345678, 32'h00007FFF, 32'h12345678};
    vecs[5] = '{ALU, 1'b0, 4'd6, 4'd1, 4'd2, 2'b00, 16'hFFFF, 32'h11111111, 32'h80000002, 32'h80000002};
    vecs[6] = '{ALU, 1'b1, 4'd7, 4'd9, 4'd9, 2'b10, 16'hFFFF, 32'h00000000, 32'hFFFF0000, 32'h00000000};
    vecs[7] = '{5'b11000, 1'b0, 4'd8, 4'd3, 4'd0, 2'b00, 16'h0000, 32'h12345678, 32'h00000000, 32'h00000000};

    clr = 1'b1;
    idle();
    tick();
    do_reset();
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_op1", bus.out_op1, 32'd0);
    check("reset out_op2", bus.out_op2, 32'd0);
    check("reset out_st", bus.out_st, 32'd0);
    check("reset out_rd", 32'(bus.out_rd), 32'd0);
    check("reset out_opcode", 32'(bus.out_opcode), 32'd0);
    check("reset out_wr", 32'(bus.out_wr), 32'd0);

    for (int r = 1; r < 16; r++) begin
      drive(ALU, 1'b1, 4'd0, 4'(r), 4'd0, 2'b00, 16'h0);
      tick();
      check("reset reg read", bus.out_op1, 32'd0);
    end
    idle();
    tick();

    wb(4'd1, 32'h11111111);
    wb(4'd2, 32'h80000002);
    wb(4'd3, 32'h12345678);
    foreach (vecs[i]) begin
      drive(vecs[i].opcode, vecs[i].ior, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
            vecs[i].modifier, vecs[i].imm);
      #1;
      check("vec in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      check("vec out_valid", 32'(bus.out_valid), 32'd1);
      check("vec out_opcode", 32'(bus.out_opcode), 32'(vecs[i].opcode));
      check("vec out_rd", 32'(bus.out_rd), 32'(vecs[i].rd));
      check("vec out_wr", 32'(bus.out_wr), 32'd0);
      check("vec out_op1", bus.out_op1, vecs[i].exp_op1);
      check("vec out_op2", bus.out_op2, vecs[i].exp_op2);
      check("vec out_st", bus.out_st, vecs[i].exp_st);
    end
    idle();
    tick();

    // RAW stall on r5 released by writeback
    drive(WR, 1'b1, 4'd5, 4'd0, 4'd0, 2'b00, 16'h0);
    tick();
    check("raw writer wr", 32'(bus.out_wr), 32'd1);
    drive(ALU, 1'b1, 4'd0, 4'd5, 4'd0, 2'b00, 16'h0);
    #1;
    check("raw stall 1", 32'(bus.in_ready), 32'd0);
    tick();
    check("raw stall 2", 32'(bus.in_ready), 32'd0);
    bus.wb_en = 1'b1; bus.wb_rd = 4'd5; bus.wb_data = 32'h0000CAFE;
    #1;
`ifdef OPFETCH_WB_BYPASS_EN
    check("raw bypass ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.wb_en = 1'b0;
`else
    check("raw wb-cycle stall", 32'(bus.in_ready), 32'd0);
    tick();
    bus.wb_en = 1'b0;
    #1;
    check("raw release ready", 32'(bus.in_ready), 32'd1);
    tick();
`endif
    check("raw out_valid", 32'(bus.out_valid), 32'd1);
    check("raw op1", bus.out_op1, 32'h0000CAFE);
    idle();
    tick();

    // Backpressure holds the slot
    bus.out_ready = 1'b0;
    drive(ALU, 1'b1, 4'd0, 4'd1, 4'd0, 2'b01, 16'h0005);
    tick();
    check("bp A op1", bus.out_op1, 32'h11111111);
    drive(ALU, 1'b1, 4'd0, 4'd2, 4'd0, 2'b01, 16'h0009);
    #1;
    check("bp stall ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("bp hold valid", 32'(bus.out_valid), 32'd1);
    check("bp hold op1", bus.out_op1, 32'h11111111);
    check("bp hold op2", bus.out_op2, 32'h00000005);
    bus.out_ready = 1'b1;
    #1;
    check("bp release ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("bp B op1", bus.out_op1, 32'h80000002);
    check("bp B op2", bus.out_op2, 32'h00000009);
    idle();
    tick();

    // Flush discards a held writer and frees its rd
    bus.out_ready = 1'b0;
    drive(WR, 1'b1, 4'd7, 4'd0, 4'd0, 2'b00, 16'h0);
    tick();
    check("flush slot rd", 32'(bus.out_rd), 32'd7);
    bus.in_valid = 1'b0;
    bus.flush = 1'b1;
    #1;
    check("flush ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.flush = 1'b0;
    check("flush out_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    drive(ALU, 1'b1, 4'd0, 4'd7, 4'd0, 2'b00, 16'h0);
    #1;
    check("flush r7 free", 32'(bus.in_ready), 32'd1);
    tick();
    check("flush reader issued", 32'(bus.out_valid), 32'd1);
    idle();
    tick();

    // Same-cycle issue and writeback of r4: busy stays set
    drive(WR, 1'b1, 4'd4, 4'd0, 4'd0, 2'b00, 16'h0);
    bus.wb_en = 1'b1; bus.wb_rd = 4'd4; bus.wb_data = 32'h00000044;
    #1;
    check("setwin issue ready", 32'(bus.in_ready), 32'd1);
    tick();
    idle();
    drive(ALU, 1'b1, 4'd0, 4'd4, 4'd0, 2'b00, 16'h0);
    #1;
    check("setwin r4 busy", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    tick();
    wb(4'd4, 32'h00000099);
    drive(ALU, 1'b1, 4'd0, 4'd4, 4'd0, 2'b00, 16'h0);
    #1;
    check("setwin r4 free", 32'(bus.in_ready), 32'd1);
    tick();
    check("setwin r4 value", bus.out_op1, 32'h00000099);
    idle();

    // r0 ignores writes
    wb(4'd0, 32'hFFFFFFFF);
    drive(ALU, 1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 16'h0);
    tick();
    check("r0 op1", bus.out_op1, 32'd0);
    check("r0 st", bus.out_st, 32'd0);
    idle();
    tick();

    // clr during a stall drops everything
    drive(WR, 1'b1, 4'd9, 4'd0, 4'd0, 2'b00, 16'h0);
    tick();
    drive(ALU, 1'b1, 4'd0, 4'd9, 4'd0, 2'b00, 16'h0);
    #1;
    check("clr pre stall", 32'(bus.in_ready), 32'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    bus.in_valid = 1'b0;
    check("clr out_valid", 32'(bus.out_valid), 32'd0);
    check("clr out_rd", 32'(bus.out_rd), 32'd0);
    drive(ALU, 1'b1, 4'd0, 4'd9, 4'd3, 2'b00, 16'h0);
    #1;
    check("clr busy cleared", 32'(bus.in_ready), 32'd1);
    tick();
    check("clr reg cleared", bus.out_st, 32'd0);

    // randomized run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) rand_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
